mach_bus_ctl: RTL and testbench

- Parametrised CPU-side bus cycle controller for the machine assembly.
- Takes a V810 bus cycle (BCYSTn-started) plus a one-hot slave select from the gate-array decoder.
- Drives per-slave chip select, RDn/WRn strobes and programmable wait states, and returns READYn and read data to the CPU.
- Generalises the fixed ROM/RAM/IO readback mux to NSLV slaves. Adds 32-to-16-bit dynamic bus sizing (two-half split cycles), minimum-wait insertion and a bus timeout.

---
 rtl/mach_bus_ctl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_mach_bus_ctl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mach_bus_ctl.sv
// mach_bus_ctl: V810 CPU-side bus cycle controller with per-slave wait states and 32->16 bit sizing.
// Optional bus timeout is compiled in when MACH_BUS_TIMEOUT_EN is defined.
module mach_bus_ctl #(
    parameter int          NSLV      = 8,
    parameter logic [15:0] WIDE16    = 16'h0000,
    parameter logic [63:0] WAIT_CNT  = 64'h0,
    parameter int          TO_CYCLES = 255
) (
    input  logic                 CLK,
    input  logic                 RES,
    input  logic                 CE,
    input  logic [31:0]          CPU_A,
    input  logic [31:0]          CPU_DO,
    output logic [31:0]          CPU_DI,
    input  logic [3:0]           CPU_BEn,
    input  logic                 CPU_RW,
    input  logic                 CPU_BCYSTn,
    output logic                 CPU_READYn,
    input  logic [NSLV-1:0]      SEL,
    output logic [NSLV-1:0]      S_CSn,
    output logic [31:0]          S_A,
    output logic [31:0]          S_DI,
    output logic [3:0]           S_BEn,
    output logic                 S_RDn,
    output logic                 S_WRn,
    input  logic [NSLV*32-1:0]   S_DO,
    input  logic [NSLV-1:0]      S_READYn,
    output logic                 TIMEOUT
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_GAP    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic [3:0] half_ben(input logic wide, input logic upper, input logic [3:0] ben);
        if (!wide) begin
            half_ben = ben;
        end else if (upper) begin
            half_ben = {2'b11, ben[3:2]};
        end else begin
            half_ben = {2'b11, ben[1:0]};
        end
    endfunction

    function automatic logic [31:0] half_di(input logic wide, input logic upper, input logic [31:0] wdata);
        half_di = (wide && upper) ? {16'h0000, wdata[31:16]} : wdata;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] ben);
        lane_mask = {{8{~ben[3]}}, {8{~ben[2]}}, {8{~ben[1]}}, {8{~ben[0]}}};
    endfunction

    state_t            state_r;
    logic [31:0]       do_r;
    logic [3:0]        ben_r;
    logic              rw_r;
    logic [3:0]        idx_r;
    logic              wide_r;
    logic              split_r;
    logic              half_r;
    logic [3:0]        wait_ld_r;
    logic [3:0]        wait_r;
    logic [31:0]       data_r;
    logic [31:0]       cpu_di_r;
    logic              cpu_readyn_r;
    logic [NSLV-1:0]   s_csn_r;
    logic [31:0]       s_a_r;
    logic [31:0]       s_di_r;
    logic [3:0]        s_ben_r;
    logic              s_rdn_r;
    logic              s_wrn_r;
    logic              timeout_r;

    logic [3:0]        sel_idx_s;
    logic              new_wide_s;
    logic [3:0]        new_wait_s;
    logic [NSLV-1:0]   sel_csn_s;
    logic [NSLV-1:0]   cur_csn_s;
    logic              cur_rdyn_s;
    logic [31:0]       cur_do_s;
    logic              lower_act_s;
    logic              upper_act_s;
    logic              new_split_s;
    logic              new_upper_s;
    logic              done_half_s;
    logic [31:0]       cap_raw_s;
    logic [31:0]       cap_mask_s;
    logic [31:0]       data_next_s;
    logic              to_hit_s;

`ifdef MACH_BUS_TIMEOUT_EN
    logic [15:0]       to_cnt_r;
    assign to_hit_s = (to_cnt_r == 16'(TO_CYCLES - 1));
`else
    // Never fires; the term only keeps TO_CYCLES referenced when the timeout is not built.
    assign to_hit_s = 1'b0 & (TO_CYCLES == 0);
`endif

    // Slave lookups: lowest set SEL bit for a new cycle, latched index for the cycle in flight.
    always_comb begin
        sel_idx_s = 4'd0;
        for (int k = NSLV - 1; k >= 0; k--) begin
            sel_idx_s = SEL[k] ? 4'(k) : sel_idx_s;
        end
        new_wide_s = 1'b0;
        new_wait_s = 4'd0;
        sel_csn_s  = {NSLV{1'b1}};
        cur_csn_s  = {NSLV{1'b1}};
        cur_rdyn_s = 1'b1;
        cur_do_s   = 32'h0;
        for (int k = 0; k < NSLV; k++) begin
            if (sel_idx_s == 4'(k)) begin
                new_wide_s   = WIDE16[k];
                new_wait_s   = WAIT_CNT[4*k +: 4];
                sel_csn_s[k] = 1'b0;
            end else begin
                sel_csn_s[k] = 1'b1;
            end
            if (idx_r == 4'(k)) begin
                cur_rdyn_s   = S_READYn[k];
                cur_do_s     = S_DO[32*k +: 32];
                cur_csn_s[k] = 1'b0;
            end else begin
                cur_csn_s[k] = 1'b1;
            end
        end
    end

    // Half planning for the incoming cycle and read-lane assembly for the current half.
    always_comb begin
        lower_act_s = (CPU_BEn[1:0] != 2'b11);
        upper_act_s = (CPU_BEn[3:2] != 2'b11);
        new_split_s = new_wide_s & lower_act_s & upper_act_s;
        new_upper_s = new_wide_s & ~lower_act_s & upper_act_s;
        done_half_s = (wait_r == 4'd0) && !cur_rdyn_s;
        if (wide_r && half_r) begin
            cap_raw_s  = {cur_do_s[15:0], 16'h0000};
            cap_mask_s = lane_mask({ben_r[3:2], 2'b11});
        end else if (wide_r) begin
            cap_raw_s  = cur_do_s;
            cap_mask_s = lane_mask({2'b11, ben_r[1:0]});
        end else begin
            cap_raw_s  = cur_do_s;
            cap_mask_s = lane_mask(ben_r);
        end
        data_next_s = data_r | (cap_raw_s & cap_mask_s);
    end

    // Bus cycle sequencer; every output is a register and moves only when CE is high.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_r      <= ST_IDLE;
            do_r         <= 32'h0;
            ben_r        <= 4'hF;
            rw_r         <= 1'b1;
            idx_r        <= 4'd0;
            wide_r       <= 1'b0;
            split_r      <= 1'b0;
            half_r       <= 1'b0;
            wait_ld_r    <= 4'd0;
            wait_r       <= 4'd0;
            data_r       <= 32'h0;
            cpu_di_r     <= 32'h0;
            cpu_readyn_r <= 1'b1;
            s_csn_r      <= {NSLV{1'b1}};
            s_a_r        <= 32'h0;
            s_di_r       <= 32'h0;
            s_ben_r      <= 4'hF;
            s_rdn_r      <= 1'b1;
            s_wrn_r      <= 1'b1;
            timeout_r    <= 1'b0;
`ifdef MACH_BUS_TIMEOUT_EN
            to_cnt_r     <= 16'h0;
`endif
        end else if (CE) begin
            cpu_readyn_r <= 1'b1;
            timeout_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!CPU_BCYSTn) begin
                        do_r      <= CPU_DO;
                        ben_r     <= CPU_BEn;
                        rw_r      <= CPU_RW;
                        idx_r     <= sel_idx_s;
                        wide_r    <= new_wide_s;
                        split_r   <= new_split_s;
                        half_r    <= new_upper_s;
                        wait_ld_r <= new_wait_s;
                        wait_r    <= new_wait_s;
                        data_r    <= 32'h0;
                        s_a_r     <= {CPU_A[31:2], (new_wide_s ? new_upper_s : CPU_A[1]), CPU_A[0]};
                        s_di_r    <= half_di(new_wide_s, new_upper_s, CPU_DO);
                        s_ben_r   <= half_ben(new_wide_s, new_upper_s, CPU_BEn);
`ifdef MACH_BUS_TIMEOUT_EN
                        to_cnt_r  <= 16'h0;
`endif
                        if (SEL == {NSLV{1'b0}}) begin
                            state_r      <= ST_DONE;
                            cpu_readyn_r <= 1'b0;
                            cpu_di_r     <= 32'h0;
                        end else begin
                            state_r <= ST_STROBE;
                            s_csn_r <= sel_csn_s;
                            s_rdn_r <= ~CPU_RW;
                            s_wrn_r <= CPU_RW;
                        end
                    end
                end
                ST_STROBE: begin
                    wait_r <= (wait_r == 4'd0) ? 4'd0 : wait_r - 4'd1;
`ifdef MACH_BUS_TIMEOUT_EN
                    to_cnt_r <= to_cnt_r + 16'd1;
`endif
                    if (done_half_s) begin
                        data_r  <= data_next_s;
                        s_csn_r <= {NSLV{1'b1}};
                        s_rdn_r <= 1'b1;
                        s_wrn_r <= 1'b1;
                        if (split_r && !half_r) begin
                            state_r  <= ST_GAP;
                            half_r   <= 1'b1;
                            s_a_r[1] <= 1'b1;
                            s_di_r   <= half_di(1'b1, 1'b1, do_r);
                            s_ben_r  <= half_ben(1'b1, 1'b1, ben_r);
                        end else begin
                            state_r      <= ST_DONE;
                            cpu_readyn_r <= 1'b0;
                            cpu_di_r     <= rw_r ? data_next_s : 32'h0;
                        end
                    end else if (to_hit_s) begin
                        state_r      <= ST_DONE;
                        s_csn_r      <= {NSLV{1'b1}};
                        s_rdn_r      <= 1'b1;
                        s_wrn_r      <= 1'b1;
                        cpu_readyn_r <= 1'b0;
                        cpu_di_r     <= 32'h0;
                        timeout_r    <= 1'b1;
                    end
                end
                ST_GAP: begin
`ifdef MACH_BUS_TIMEOUT_EN
                    to_cnt_r <= to_cnt_r + 16'd1;
`endif
                    if (to_hit_s) begin
                        state_r      <= ST_DONE;
                        cpu_readyn_r <= 1'b0;
                        cpu_di_r     <= 32'h0;
                        timeout_r    <= 1'b1;
                    end else begin
                        state_r <= ST_STROBE;
                        wait_r  <= wait_ld_r;
                        s_csn_r <= cur_csn_s;
                        s_rdn_r <= ~rw_r;
                        s_wrn_r <= rw_r;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign CPU_DI     = cpu_di_r;
    assign CPU_READYn = cpu_readyn_r;
    assign S_CSn      = s_csn_r;
    assign S_A        = s_a_r;
    assign S_DI       = s_di_r;
    assign S_BEn      = s_ben_r;
    assign S_RDn      = s_rdn_r;
    assign S_WRn      = s_wrn_r;
    assign TIMEOUT    = timeout_r;

endmodule

// File: tb/tb_mach_bus_ctl.sv
// Directed bench for mach_bus_ctl: slave 0 has 3 wait states, slave 3 is 16-bit, timeout at 10 CE.
module tb_mach_bus_ctl;

    logic         clk = 1'b0;
    logic         res = 1'b1;
    logic         ce = 1'b1;
    logic [31:0]  cpu_a = 32'h0;
    logic [31:0]  cpu_do = 32'h0;
    logic [31:0]  cpu_di;
    logic [3:0]   cpu_ben = 4'hF;
    logic         cpu_rw = 1'b1;
    logic         cpu_bcystn = 1'b1;
    logic         cpu_readyn;
    logic [7:0]   sel = 8'h00;
    logic [7:0]   s_csn;
    logic [31:0]  s_a;
    logic [31:0]  s_di;
    logic [3:0]   s_ben;
    logic         s_rdn;
    logic         s_wrn;
    logic [255:0] s_do;
    logic [7:0]   s_readyn = 8'h00;
    logic         timeout;

    logic [31:0]  sdo_v [8];
    int           chk_cnt = 0;
    int           pass_cnt = 0;
    int           lat;
    int           rd_low;
    int           wr_low;
    logic [7:0]   csn_tr [64];
    logic         a1_tr  [64];
    logic         rdn_tr [64];
    logic [31:0]  di_tr  [64];
    logic [3:0]   ben_tr [64];

    always #5 clk = ~clk;

    mach_bus_ctl #(
        .NSLV      (8),
        .WIDE16    (16'h0008),
        .WAIT_CNT  (64'h0000_0000_0000_0003),
        .TO_CYCLES (10)
    ) dut (
        .CLK        (clk),
        .RES        (res),
        .CE         (ce),
        .CPU_A      (cpu_a),
        .CPU_DO     (cpu_do),
        .CPU_DI     (cpu_di),
        .CPU_BEn    (cpu_ben),
        .CPU_RW     (cpu_rw),
        .CPU_BCYSTn (cpu_bcystn),
        .CPU_READYn (cpu_readyn),
        .SEL        (sel),
        .S_CSn      (s_csn),
        .S_A        (s_a),
        .S_DI       (s_di),
        .S_BEn      (s_ben),
        .S_RDn      (s_rdn),
        .S_WRn      (s_wrn),
        .S_DO       (s_do),
        .S_READYn   (s_readyn),
        .TIMEOUT    (timeout)
    );

    // Slave 3 answers 1234 on the low half and 5678 on the high half, with junk on unused lanes.
    always_comb begin
        s_do = 256'h0;
        for (int k = 0; k < 8; k++) begin
            s_do[32*k +: 32] = sdo_v[k];
        end
        s_do[96 +: 32] = {16'hFFFF, (s_a[1] ? 16'h5678 : 16'h1234)};
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ben,
                           input logic rw, input logic [7:0] sl);
        cpu_a = a;
        cpu_do = d;
        cpu_ben = ben;
        cpu_rw = rw;
        sel = sl;
        cpu_bcystn = 1'b0;
        lat = 0;
        rd_low = 0;
        wr_low = 0;
        for (int n = 1; n < 64; n++) begin
            tick();
            cpu_bcystn = 1'b1;
            csn_tr[n] = s_csn;
            a1_tr[n]  = s_a[1];
            rdn_tr[n] = s_rdn;
            di_tr[n]  = s_di;
            ben_tr[n] = s_ben;
            if (!s_rdn) rd_low++;
            if (!s_wrn) wr_low++;
            if (!cpu_readyn) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic end_pulse(input string tag);
        tick();
        check_val(tag, 32'(cpu_readyn), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 8; k++) sdo_v[k] = 32'h0;
        sdo_v[0] = 32'h0BADF00D;
        sdo_v[1] = 32'hDEADBEEF;
        sdo_v[2] = 32'h12345678;

        tick();
        tick();
        check_val("rst_readyn", 32'(cpu_readyn), 32'h1);
        check_val("rst_csn", 32'(s_csn), 32'h0000_00FF);
        check_val("rst_rdn", 32'(s_rdn), 32'h1);
        check_val("rst_wrn", 32'(s_wrn), 32'h1);
        check_val("rst_di", cpu_di, 32'h0);
        check_val("rst_ben", 32'(s_ben), 32'h0000_000F);
        check_val("rst_timeout", 32'(timeout), 32'h0);
        res = 1'b0;

        // Async reset in the middle of a stalled slave-2 read.
        s_readyn = 8'h04;
        cpu_a = 32'h2000_0000; cpu_ben = 4'h0; cpu_rw = 1'b1; sel = 8'h04; cpu_bcystn = 1'b0;
        tick();
        cpu_bcystn = 1'b1;
        tick();
        tick();
        check_val("stall_csn", 32'(s_csn), 32'h0000_00FB);
        check_val("stall_rdn", 32'(s_rdn), 32'h0);
        check_val("stall_readyn", 32'(cpu_readyn), 32'h1);
        res = 1'b1;
        #2;
        check_val("async_csn", 32'(s_csn), 32'h0000_00FF);
        check_val("async_rdn", 32'(s_rdn), 32'h1);
        check_val("async_readyn", 32'(cpu_readyn), 32'h1);
        #1;
        res = 1'b0;
        s_readyn = 8'h00;
        tick();

        run_bus(32'h1000_0004, 32'h0, 4'h0, 1'b1, 8'h02);
        check_val("rd32_lat", 32'(lat), 32'd2);
        check_val("rd32_data", cpu_di, 32'hDEADBEEF);
        check_val("rd32_csn", 32'(csn_tr[1]), 32'h0000_00FD);
        check_val("rd32_rdn", 32'(rdn_tr[1]), 32'h0);
        check_val("rd32_timeout", 32'(timeout), 32'h0);
        end_pulse("rd32_pulse");
        check_val("rd32_hold", cpu_di, 32'hDEADBEEF);

        run_bus(32'h3000_0000, 32'h0, 4'h0, 1'b1, 8'h08);
        check_val("split_lat", 32'(lat), 32'd4);
        check_val("split_data", cpu_di, 32'h56781234);
        check_val("split_a1_first", 32'(a1_tr[1]), 32'h0);
        check_val("split_rdn_first", 32'(rdn_tr[1]), 32'h0);
        check_val("split_gap_rdn", 32'(rdn_tr[2]), 32'h1);
        check_val("split_gap_csn", 32'(csn_tr[2]), 32'h0000_00FF);
        check_val("split_a1_second", 32'(a1_tr[3]), 32'h1);
        check_val("split_rdn_second", 32'(rdn_tr[3]), 32'h0);
        end_pulse("split_pulse");

        run_bus(32'h3000_0010, 32'hAABB0000, 4'h3, 1'b0, 8'h08);
        check_val("wr16_lat", 32'(lat), 32'd2);
        check_val("wr16_wr_low", 32'(wr_low), 32'd1);
        check_val("wr16_rd_low", 32'(rd_low), 32'd0);
        check_val("wr16_a1", 32'(a1_tr[1]), 32'h1);
        check_val("wr16_di", {16'h0000, di_tr[1][15:0]}, 32'h0000AABB);
        check_val("wr16_ben", 32'(ben_tr[1]), 32'h0000_000C);
        check_val("wr16_cpu_di", cpu_di, 32'h0);
        end_pulse("wr16_pulse");

        run_bus(32'h3000_0020, 32'h0, 4'hC, 1'b1, 8'h08);
        check_val("rd16lo_lat", 32'(lat), 32'd2);
        check_val("rd16lo_a1", 32'(a1_tr[1]), 32'h0);
        check_val("rd16lo_data", cpu_di, 32'h00001234);
        end_pulse("rd16lo_pulse");

        run_bus(32'h0000_0000, 32'h0, 4'hA, 1'b1, 8'h01);
        check_val("wait_lat", 32'(lat), 32'd5);
        check_val("wait_rd_low", 32'(rd_low), 32'd4);
        check_val("wait_lanes", cpu_di, 32'h00AD000D);
        end_pulse("wait_pulse");

        run_bus(32'h1000_0000, 32'h0, 4'h3, 1'b1, 8'h06);
        check_val("multi_lat", 32'(lat), 32'd2);
        check_val("multi_csn", 32'(csn_tr[1]), 32'h0000_00FD);
        check_val("multi_data", cpu_di, 32'hDEAD0000);
        end_pulse("multi_pulse");

        run_bus(32'hF000_0000, 32'h0, 4'h0, 1'b1, 8'h00);
        check_val("unmap_lat", 32'(lat), 32'd1);
        check_val("unmap_data", cpu_di, 32'h0);
        end_pulse("unmap_pulse");

        // CE low in the middle of a wait-state read must freeze everything.
        cpu_a = 32'h0000_0040; cpu_ben = 4'h0; cpu_rw = 1'b1; sel = 8'h01; cpu_bcystn = 1'b0;
        tick();
        cpu_bcystn = 1'b1;
        ce = 1'b0;
        repeat (5) tick();
        check_val("ce_hold_rdn", 32'(s_rdn), 32'h0);
        check_val("ce_hold_csn", 32'(s_csn), 32'h0000_00FE);
        check_val("ce_hold_readyn", 32'(cpu_readyn), 32'h1);
        ce = 1'b1;
        repeat (3) tick();
        check_val("ce_wait_rdn", 32'(s_rdn), 32'h0);
        check_val("ce_wait_readyn", 32'(cpu_readyn), 32'h1);
        tick();
        check_val("ce_done_readyn", 32'(cpu_readyn), 32'h0);
        check_val("ce_done_data", cpu_di, 32'h0BADF00D);
        end_pulse("ce_pulse");

`ifdef MACH_BUS_TIMEOUT_EN
        s_readyn = 8'h04;
        run_bus(32'h2000_0000, 32'h0, 4'h0, 1'b1, 8'h04);
        check_val("to_lat", 32'(lat), 32'd11);
        check_val("to_rd_low", 32'(rd_low), 32'd10);
        check_val("to_pulse", 32'(timeout), 32'h1);
        check_val("to_data", cpu_di, 32'h0);
        check_val("to_rdn", 32'(s_rdn), 32'h1);
        tick();
        check_val("to_pulse_end", 32'(timeout), 32'h0);
        check_val("to_readyn_end", 32'(cpu_readyn), 32'h1);
        s_readyn = 8'h00;
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
